ogr_job_sequencer: RTL and testbench
====================================

Name: ogr_job_sequencer

Overview:
- Sequences the Golomb-ruler search assembly on behalf of a host.
- Accepts search jobs, each a preset start-mark vector, over a valid/ready handshake.
- For each job: drives the assembly's firstvalues, holds its reset for a programmed time, runs it until done or timeout, then returns the result record over a second valid/ready handshake.
- Replaces the stimulus and collection functions of the simulation bench, so the same flow works on a real FPGA.

Parameters:
- NUM_MARKS, 6, number of marks m[0]..m[NUM_MARKS-1].
- POS_W, 9, bits per mark position.
- CNT_W, 6, width of the assembly's result counter.
- RESET_CYCLES, 3000, clock cycles the assembly reset is held per job; legal range 1..65535.
- TIMEOUT_CYCLES, 2000000, run cycles allowed after reset release before the job is aborted; legal range 1..2^24-1.
- ID_W, 16, job-id and job-counter width.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-low.
- job_valid  in  1  host offers a job.
- job_ready  out  1  sequencer accepts the job this cycle.
- job_firstvalues  in  NUM_MARKS*POS_W  preset marks; m[0] in the MSBs.
- ruler_reset  out  1  active-high reset to the assembly.
- ruler_firstvalues  out  NUM_MARKS*POS_W  registered copy of the accepted job vector.
- ruler_done  in  1  assembly finished its search.
- ruler_num_results  in  CNT_W  optimal rulers observed by the assembly.
- ruler_marks  in  NUM_MARKS*POS_W  current marks of the assembly.
- res_valid  out  1  result record available.
- res_ready  in  1  host consumes the record.
- res_job_id  out  ID_W  id of the job this record belongs to.
- res_num_results  out  CNT_W  captured result count.
- res_marks  out  NUM_MARKS*POS_W  captured marks.
- res_timeout  out  1  job was aborted by timeout.
- busy  out  1  state is not IDLE.
- jobs_done  out  ID_W  number of records consumed by the host.

Behaviour:
- Reset values (reset==0 at a clock edge): state IDLE; ruler_reset=1; job_ready=0; res_valid=0; res_* fields=0; ruler_firstvalues=0; busy=0; jobs_done=0; next job id=0; cycle counter=0.
- States: IDLE, HOLD, RUN, REPORT.
- IDLE:
  - job_ready=1 and ruler_reset=1.
  - On job_valid&&job_ready: latch job_firstvalues into ruler_firstvalues, assign next job id, load cycle counter with RESET_CYCLES-1, go to HOLD.
  - Handshake completes in one cycle; job_ready=0 in every state other than IDLE.
- HOLD:
  - ruler_reset=1; counter decrements each cycle.
  - ruler_done is ignored in HOLD.
  - When counter==0: load counter with TIMEOUT_CYCLES-1, go to RUN.
  - ruler_reset is therefore high for exactly RESET_CYCLES cycles after acceptance, plus one IDLE cycle.
- RUN:
  - ruler_reset=0; counter decrements each cycle.
  - On ruler_done: capture ruler_num_results and ruler_marks, set res_timeout=0, go to REPORT.
  - Otherwise, at counter==0: capture the same fields, set res_timeout=1, go to REPORT.
  - If ruler_done and counter==0 occur in the same cycle, done wins and res_timeout=0.
- REPORT:
  - res_valid=1; ruler_reset=1, which re-asserts the assembly reset and freezes it.
  - All res_* fields stay stable while res_valid=1 and res_ready=0.
  - On res_ready: res_valid drops next cycle, jobs_done increments (wraps modulo 2^ID_W), job id increments (wraps), go to IDLE.
- Latency, acceptance to res_valid: RESET_CYCLES + 1 + k cycles, where k is the number of RUN cycles up to and including the cycle ruler_done is sampled (1 <= k <= TIMEOUT_CYCLES).
- Back-to-back jobs: the earliest next acceptance is the cycle after res_ready.
- No combinational path from any input to any output. All outputs are registered or decoded from state.
- Reset mid-operation: a synchronous reset in any state returns to the reset values the next edge. An in-flight job is lost without a record.
- Widths: the cycle counter is max(clog2(RESET_CYCLES), clog2(TIMEOUT_CYCLES)) bits, zero-extended. No arithmetic on mark values.

Decomposition:
- Shared definitions include gains JOB_VEC_W = NUM_MARKS*POS_W and the state encodings (IDLE=0, HOLD=1, RUN=2, REPORT=3).
- One sub-module: ogr_result_capture. It is a register slice holding res_job_id, res_num_results, res_marks and res_timeout, with load/hold control and the valid/ready flag.
- The FSM and counter stay in ogr_job_sequencer.

Test Plan:
- Single job, RESET_CYCLES=4, TIMEOUT_CYCLES=100, fv=0-1-2-3-4-5, stub raises done with count=2 and marks 0-1-4-10-12-17 on RUN cycle 7 -> ruler_reset high 5 cycles from acceptance; res_valid at acceptance+12; res_num_results=2, res_marks=0-1-4-10-12-17, res_timeout=0, res_job_id=0.
- Timeout, TIMEOUT_CYCLES=10, done never rises -> res_valid after 4+1+10 cycles; res_timeout=1; res_marks equals stub marks in the last RUN cycle.
- Backpressure, res_ready held low 20 cycles -> res_* fields constant; job_ready=0 throughout; jobs_done increments only at the res_ready cycle.
- Three back-to-back jobs with job_valid held high -> res_job_id 0, 1, 2; jobs_done=3; one IDLE cycle between each REPORT and the next HOLD.
- Done pulse during HOLD, plus done coinciding with counter==0 in RUN -> HOLD pulse ignored; coincident case gives res_timeout=0.
- Reset driven low during RUN -> next edge: ruler_reset=1, busy=0, res_valid=0, jobs_done=0; the next job receives id 0.

Source files
------------

// File: rtl/ogr_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ogr_job_sequencer_pkg
// Shared definitions for the Golomb-ruler job sequencer:
//   - seq_state_t : sequencer FSM states (IDLE=0, HOLD=1, RUN=2, REPORT=3)
//   - JOB_VEC_W   : packed mark-vector width for the default geometry
//   - job_vec_w() : packed mark-vector width for any geometry
//   - cnt_w()     : width of the shared HOLD/RUN cycle counter
// -----------------------------------------------------------------------------
package ogr_job_sequencer_pkg;

    localparam int DEF_NUM_MARKS = 6;
    localparam int DEF_POS_W     = 9;
    localparam int JOB_VEC_W     = DEF_NUM_MARKS * DEF_POS_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } seq_state_t;

    function automatic int job_vec_w(input int num_marks, input int pos_w);
        return num_marks * pos_w;
    endfunction

    // One counter serves both the reset hold and the run timeout, so it is
    // sized for the larger of the two load values (N-1 fits in clog2(N) bits).
    // Never narrower than one bit, so a 1-cycle/1-cycle build still elaborates.
    function automatic int cnt_w(input int reset_cycles, input int timeout_cycles);
        int a;
        int b;
        int w;
        a = $clog2(reset_cycles);
        b = $clog2(timeout_cycles);
        w = (a > b) ? a : b;
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ogr_job_sequencer_result_capture.sv
// -----------------------------------------------------------------------------
// ogr_result_capture
// Register slice for one result record plus its valid/ready flag.
// A load pulse captures all fields and raises o_valid; the fields then hold
// until the next load, and o_valid drops the cycle after i_ready is seen.
// Ports:
//   clock, reset       system clock, synchronous active-low reset
//   i_load             capture the i_* fields this cycle
//   i_job_id           id of the job being reported
//   i_num_results      result count from the assembly
//   i_marks            mark vector from the assembly
//   i_timeout          record is the product of a timeout abort
//   i_ready            host consumes the record
//   o_valid            record available
//   o_job_id, o_num_results, o_marks, o_timeout   captured fields
// -----------------------------------------------------------------------------
module ogr_result_capture
    import ogr_job_sequencer_pkg::*;
#(
    parameter int VEC_W = JOB_VEC_W,
    parameter int CNT_W = 6,
    parameter int ID_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [ID_W-1:0]  i_job_id,
    input  logic [CNT_W-1:0] i_num_results,
    input  logic [VEC_W-1:0] i_marks,
    input  logic             i_timeout,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_job_id,
    output logic [CNT_W-1:0] o_num_results,
    output logic [VEC_W-1:0] o_marks,
    output logic             o_timeout
);

    logic             r_valid;
    logic [ID_W-1:0]  r_job_id;
    logic [CNT_W-1:0] r_num_results;
    logic [VEC_W-1:0] r_marks;
    logic             r_timeout;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid       <= 1'b0;
            r_job_id      <= '0;
            r_num_results <= '0;
            r_marks       <= '0;
            r_timeout     <= 1'b0;
        end else begin
            if (i_load) begin
                r_valid       <= 1'b1;
                r_job_id      <= i_job_id;
                r_num_results <= i_num_results;
                r_marks       <= i_marks;
                r_timeout     <= i_timeout;
            end else if (r_valid && i_ready) begin
                // Fields are left untouched: only the flag retires.
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_job_id      = r_job_id;
    assign o_num_results = r_num_results;
    assign o_marks       = r_marks;
    assign o_timeout     = r_timeout;

endmodule

// File: rtl/ogr_job_sequencer.sv
// -----------------------------------------------------------------------------
// ogr_job_sequencer
// Drives the Golomb-ruler search assembly on behalf of a host: accepts a job
// (preset start marks), holds the assembly in reset for RESET_CYCLES, lets it
// run until ruler_done or TIMEOUT_CYCLES expire, then hands back a result
// record. FSM: IDLE -> HOLD -> RUN -> REPORT -> IDLE.
// Ports:
//   clock, reset                system clock, synchronous active-low reset
//   job_valid/job_ready         job handshake (ready only in IDLE)
//   job_firstvalues             preset marks, m[0] in the MSBs
//   ruler_reset                 active-high reset to the assembly
//   ruler_firstvalues           registered copy of the accepted job vector
//   ruler_done                  assembly finished (sampled in RUN only)
//   ruler_num_results           assembly result counter
//   ruler_marks                 assembly current marks
//   res_valid/res_ready         result handshake
//   res_job_id, res_num_results, res_marks, res_timeout   result record
//   busy                        state is not IDLE
//   jobs_done                   records consumed by the host (wraps)
// All outputs are registers or decodes of the state register.
// -----------------------------------------------------------------------------
module ogr_job_sequencer
    import ogr_job_sequencer_pkg::*;
#(
    parameter int NUM_MARKS      = 6,
    parameter int POS_W          = 9,
    parameter int CNT_W          = 6,
    parameter int RESET_CYCLES   = 3000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int ID_W           = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [NUM_MARKS*POS_W-1:0] job_firstvalues,
    output logic                       ruler_reset,
    output logic [NUM_MARKS*POS_W-1:0] ruler_firstvalues,
    input  logic                       ruler_done,
    input  logic [CNT_W-1:0]           ruler_num_results,
    input  logic [NUM_MARKS*POS_W-1:0] ruler_marks,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_W-1:0]            res_job_id,
    output logic [CNT_W-1:0]           res_num_results,
    output logic [NUM_MARKS*POS_W-1:0] res_marks,
    output logic                       res_timeout,
    output logic                       busy,
    output logic [ID_W-1:0]            jobs_done
);

    localparam int VEC_W = job_vec_w(NUM_MARKS, POS_W);
    localparam int CW    = cnt_w(RESET_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_job_ready;
    logic [VEC_W-1:0] r_firstvalues;
    logic [ID_W-1:0]  r_next_id;
    logic [ID_W-1:0]  r_jobs_done;

    logic             w_accept;
    logic             w_consume;
    logic             w_capture;
    logic             w_cap_timeout;
    logic             w_res_valid;

    assign w_accept  = r_job_ready && job_valid;
    assign w_consume = w_res_valid && res_ready;

    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_capture     = 1'b0;
        w_cap_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_HOLD;
                    w_cnt_next   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                // ruler_done is deliberately not looked at while the
                // assembly is still being held in reset.
                if (r_cnt == '0) begin
                    w_next_state = ST_RUN;
                    w_cnt_next   = RUN_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            ST_RUN: begin
                // done is tested first so that a finish on the very last
                // allowed cycle is reported as a genuine result.
                if (ruler_done) begin
                    w_capture     = 1'b1;
                    w_cap_timeout = 1'b0;
                    w_next_state  = ST_REPORT;
                end else if (r_cnt == '0) begin
                    w_capture     = 1'b1;
                    w_cap_timeout = 1'b1;
                    w_next_state  = ST_REPORT;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            ST_REPORT: begin
                if (w_consume) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_job_ready   <= 1'b0;
            r_firstvalues <= '0;
            r_next_id     <= '0;
            r_jobs_done   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            // Registered so ready is low on the first cycle out of reset and
            // otherwise mirrors "state is IDLE".
            r_job_ready <= (w_next_state == ST_IDLE);
            if (w_accept) begin
                r_firstvalues <= job_firstvalues;
            end
            if (w_consume) begin
                r_next_id   <= r_next_id + ID_W'(1);
                r_jobs_done <= r_jobs_done + ID_W'(1);
            end
        end
    end

    // The running job keeps r_next_id until its record is consumed, so it
    // is also the id stamped into the record.
    ogr_result_capture #(
        .VEC_W (VEC_W),
        .CNT_W (CNT_W),
        .ID_W  (ID_W)
    ) u_capture (
        .clock         (clock),
        .reset         (reset),
        .i_load        (w_capture),
        .i_job_id      (r_next_id),
        .i_num_results (ruler_num_results),
        .i_marks       (ruler_marks),
        .i_timeout     (w_cap_timeout),
        .i_ready       (res_ready),
        .o_valid       (w_res_valid),
        .o_job_id      (res_job_id),
        .o_num_results (res_num_results),
        .o_marks       (res_marks),
        .o_timeout     (res_timeout)
    );

    assign res_valid         = w_res_valid;
    assign job_ready         = r_job_ready;
    assign ruler_reset       = (r_state != ST_RUN);
    assign busy              = (r_state != ST_IDLE);
    assign ruler_firstvalues = r_firstvalues;
    assign jobs_done         = r_jobs_done;

endmodule

// File: tb/tb_ogr_job_sequencer.sv
module tb_ogr_job_sequencer;

    localparam int NM  = 6;
    localparam int PW  = 9;
    localparam int CW  = 6;
    localparam int R   = 4;
    localparam int T   = 10;
    localparam int IDW = 16;
    localparam int VW  = NM * PW;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           job_valid = 1'b0;
    logic           job_ready;
    logic [VW-1:0]  job_firstvalues = '0;
    logic           ruler_reset;
    logic [VW-1:0]  ruler_firstvalues;
    logic           ruler_done = 1'b0;
    logic [CW-1:0]  ruler_num_results = '0;
    logic [VW-1:0]  ruler_marks = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [IDW-1:0] res_job_id;
    logic [CW-1:0]  res_num_results;
    logic [VW-1:0]  res_marks;
    logic           res_timeout;
    logic           busy;
    logic [IDW-1:0] jobs_done;

    always #5 clock = ~clock;

    ogr_job_sequencer #(
        .NUM_MARKS      (NM),
        .POS_W          (PW),
        .CNT_W          (CW),
        .RESET_CYCLES   (R),
        .TIMEOUT_CYCLES (T),
        .ID_W           (IDW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_firstvalues   (job_firstvalues),
        .ruler_reset       (ruler_reset),
        .ruler_firstvalues (ruler_firstvalues),
        .ruler_done        (ruler_done),
        .ruler_num_results (ruler_num_results),
        .ruler_marks       (ruler_marks),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_job_id        (res_job_id),
        .res_num_results   (res_num_results),
        .res_marks         (res_marks),
        .res_timeout       (res_timeout),
        .busy              (busy),
        .jobs_done         (jobs_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- assembly stub ----------------
    // Counts RUN cycles since ruler_reset fell; raises done on RUN cycle
    // stub_done_at (0 = never). Marks carry the RUN cycle number in m[5].
    int             run_cnt = 0;
    int             stub_done_at = 0;
    logic           stub_hold_done = 1'b0;
    logic [CW-1:0]  stub_count = '0;
    logic [VW-1:0]  stub_done_marks = '0;

    always @(negedge clock) begin
        if (ruler_reset) begin
            run_cnt    = 0;
            ruler_done = stub_hold_done;
            ruler_marks = '0;
        end else begin
            run_cnt++;
            ruler_done = (stub_done_at != 0) && (run_cnt == stub_done_at);
            ruler_marks = ruler_done ? stub_done_marks
                                     : {9'd0, 9'd1, 9'd3, 9'd7, 9'd12, 9'(run_cnt)};
        end
        ruler_num_results = stub_count;
    end

    // ---------------- behavioural model ----------------
    // Tracks a job by its age in cycles since acceptance: the first R cycles
    // are the reset hold, RUN cycle k is age R+k, and the job ends on done
    // or at k == T.
    bit             m_active = 0;
    bit             m_report = 0;
    bit             m_rdy = 0;
    int             m_age = 0;
    int             m_p;
    logic [VW-1:0]  m_fv = '0;
    logic [VW-1:0]  m_marks = '0;
    logic [CW-1:0]  m_num = '0;
    logic           m_to = 1'b0;
    logic [IDW-1:0] m_id = '0;
    logic [IDW-1:0] m_resid = '0;
    logic [IDW-1:0] m_done = '0;
    bit             cmp_en = 0;

    always @(posedge clock) begin
        if (!reset) begin
            m_active = 0; m_report = 0; m_rdy = 0; m_age = 0;
            m_fv = '0; m_marks = '0; m_num = '0; m_to = 1'b0;
            m_id = '0; m_resid = '0; m_done = '0;
        end else begin
            if (!m_active && !m_report) begin
                if (m_rdy && job_valid) begin
                    m_active = 1; m_age = 0; m_fv = job_firstvalues;
                end
            end else if (m_active) begin
                m_p = m_age + 1;
                if (m_p > R && (ruler_done || (m_p - R) == T)) begin
                    m_active = 0; m_report = 1;
                    m_num = ruler_num_results; m_marks = ruler_marks;
                    m_to = !ruler_done; m_resid = m_id;
                end
                m_age = m_p;
            end else if (res_ready) begin
                m_report = 0; m_done = m_done + 1'b1; m_id = m_id + 1'b1;
            end
            m_rdy = !m_active && !m_report;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("job_ready", job_ready, m_rdy);
            chk("ruler_reset", ruler_reset, !(m_active && m_age >= R));
            chk("busy", busy, m_active || m_report);
            chk("res_valid", res_valid, m_report);
            chk("res_job_id", res_job_id, m_resid);
            chk("res_num_results", res_num_results, m_num);
            chk("res_marks", res_marks, m_marks);
            chk("res_timeout", res_timeout, m_to);
            chk("jobs_done", jobs_done, m_done);
            chk("ruler_firstvalues", ruler_firstvalues, m_fv);
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge with the DUT idle; returns at the negedge where
    // res_valid is first seen. lat counts cycles from acceptance, rr_hi the
    // cycles ruler_reset stayed high starting at the acceptance cycle.
    task automatic start_job(input logic [VW-1:0] fv, input int done_at,
                             output int lat, output int rr_hi);
        int  g;
        bit  rr_phase;
        stub_done_at    = done_at;
        job_firstvalues = fv;
        job_valid       = 1'b1;
        lat = 0; rr_hi = 0; g = 0;
        while (!job_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        chk("accept_wait", job_ready, 1);
        rr_phase = ruler_reset;
        rr_hi    = ruler_reset ? 1 : 0;
        @(negedge clock);
        job_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 100) begin
            if (rr_phase && ruler_reset) rr_hi++;
            else rr_phase = 0;
            @(negedge clock);
            lat++;
        end
        chk("res_valid_wait", res_valid, 1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
    endtask

    int            lat;
    int            rr_hi;
    int            g;
    logic [63:0]   snap_marks;
    logic [63:0]   snap_misc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        cmp_en = 1;
        @(negedge clock);
        chk("rst_ruler_reset", ruler_reset, 1);
        chk("rst_job_ready", job_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_firstvalues", ruler_firstvalues, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single job, done on RUN cycle 7.
        stub_count      = 6'd2;
        stub_done_marks = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
        start_job({9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5}, 7, lat, rr_hi);
        chk("job1_latency", lat, 12);
        chk("job1_rr_high", rr_hi, 5);
        chk("job1_fv", ruler_firstvalues, {9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5});
        chk("job1_num", res_num_results, 2);
        chk("job1_marks", res_marks, {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17});
        chk("job1_timeout", res_timeout, 0);
        chk("job1_id", res_job_id, 0);
        consume();
        chk("job1_valid_drop", res_valid, 0);
        chk("job1_jobs_done", jobs_done, 1);
        chk("job1_idle_ready", job_ready, 1);

        // Timeout: done never rises.
        stub_count = 6'd5;
        start_job({9'd0, 9'd2, 9'd5, 9'd9, 9'd14, 9'd20}, 0, lat, rr_hi);
        chk("to_latency", lat, 15);
        chk("to_flag", res_timeout, 1);
        chk("to_marks", res_marks, {9'd0, 9'd1, 9'd3, 9'd7, 9'd12, 9'd10});
        chk("to_num", res_num_results, 5);
        chk("to_id", res_job_id, 1);
        consume();
        chk("to_jobs_done", jobs_done, 2);

        // Backpressure: res_ready low for 20 cycles.
        stub_count      = 6'd7;
        stub_done_marks = {9'd0, 9'd3, 9'd4, 9'd9, 9'd11, 9'd16};
        start_job({9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1}, 3, lat, rr_hi);
        chk("bp_latency", lat, 8);
        snap_marks = 64'(res_marks);
        snap_misc  = {39'd0, res_job_id, res_num_results, 2'b00, res_timeout};
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("bp_marks_stable", res_marks, snap_marks);
            chk("bp_misc_stable", {39'd0, res_job_id, res_num_results, 2'b00, res_timeout}, snap_misc);
            chk("bp_job_ready_low", job_ready, 0);
            chk("bp_jobs_done_hold", jobs_done, 2);
        end
        chk("bp_id", res_job_id, 2);
        consume();
        chk("bp_jobs_done_inc", jobs_done, 3);

        // done pulse during HOLD is ignored; done on RUN cycle T wins over timeout.
        stub_count      = 6'd3;
        stub_done_marks = {9'd0, 9'd2, 9'd7, 9'd13, 9'd16, 9'd17};
        stub_hold_done  = 1'b1;
        start_job({9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd7}, T, lat, rr_hi);
        stub_hold_done  = 1'b0;
        chk("coinc_latency", lat, 15);
        chk("coinc_timeout", res_timeout, 0);
        chk("coinc_marks", res_marks, {9'd0, 9'd2, 9'd7, 9'd13, 9'd16, 9'd17});
        chk("coinc_id", res_job_id, 3);
        consume();

        // Reset in the middle of RUN drops the job.
        stub_done_at = 0;
        job_valid    = 1'b1;
        @(negedge clock);
        job_valid = 1'b0;
        g = 0;
        while (ruler_reset && g < 20) begin
            @(negedge clock);
            g++;
        end
        chk("mid_reached_run", ruler_reset, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_ruler_reset", ruler_reset, 1);
        chk("mid_busy", busy, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_jobs_done", jobs_done, 0);
        reset = 1'b1;
        @(negedge clock);

        // Three back-to-back jobs with job_valid and res_ready held high.
        stub_done_at = 2;
        job_valid    = 1'b1;
        res_ready    = 1'b1;
        for (int j = 0; j < 3; j++) begin
            g = 0;
            while (!res_valid && g < 60) begin
                @(negedge clock);
                g++;
            end
            chk("b2b_valid", res_valid, 1);
            chk("b2b_id", res_job_id, j);
            if (j == 2) job_valid = 1'b0;
            @(negedge clock);
            chk("b2b_idle_busy", busy, 0);
            chk("b2b_idle_ready", job_ready, 1);
            if (j < 2) begin
                @(negedge clock);
                chk("b2b_hold_busy", busy, 1);
                chk("b2b_hold_reset", ruler_reset, 1);
            end
        end
        res_ready = 1'b0;
        chk("b2b_jobs_done", jobs_done, 3);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
